// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : inst_fetch_unit_pkg
// Brief  : Shared widths and FSM encodings for the instruction-fetch front end.
// Rev    : 1.0  initial release
// ============================================================================
package inst_fetch_unit_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_MAX_OUTST = 4;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module : inst_fetch_unit_if
// Brief  : Memory request/response, decode hand-off and control bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt_req;
    logic              halted;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready, redirect_valid, redirect_pc, halt_req,
        output halted
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready, redirect_valid, redirect_pc, halt_req,
        input  halted
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : inst_fetch_unit_sync_fifo
// Brief  : Registered prefetch FIFO with flush; head is visible the cycle after push.
// Rev    : 1.0  initial release
// ============================================================================
module inst_fetch_unit_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : inst_fetch_unit
// Brief  : Decoupled fetch front end: PC, credit-based issue, redirect/discard, halt.
// Rev    : 1.0  initial release
// ============================================================================
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                DEPTH     = DEF_DEPTH,
    parameter int                MAX_OUTST = DEF_MAX_OUTST,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int SW = CW + 1;
    localparam int FW = ADDR_W + DATA_W;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [OW-1:0]     r_outst;
    logic [OW-1:0]     r_discard;
    logic [OW-1:0]     w_outst_next;
    logic [CW-1:0]     w_fifo_count;
    logic [FW-1:0]     w_fifo_rd;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_issue;
    logic              w_accept;
    logic              w_rsp;
    logic              w_keep;
    logic              w_pop;
    logic              w_credit_ok;

    assign w_rsp        = bus.imem_rsp_valid;
    assign w_accept     = w_issue & bus.imem_req_ready;
    assign w_keep       = w_rsp & ~bus.redirect_valid & (r_discard == '0);
    assign w_pop        = ~w_fifo_empty & bus.inst_ready;
    assign w_outst_next = r_outst + OW'(w_accept) - OW'(w_rsp);
    assign w_credit_ok  = ((SW'(w_fifo_count) + SW'(r_outst)) < SW'(DEPTH))
                        & (r_outst < OW'(MAX_OUTST));

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            S_RUN: begin
                w_issue = ~rst & ~bus.halt_req & ~bus.redirect_valid & w_credit_ok;
                if (bus.halt_req) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!bus.halt_req)      w_state_next = S_RUN;
                else if (r_outst == '0) w_state_next = S_HALT;
            end
            S_HALT: begin
                if (!bus.halt_req) w_state_next = S_RUN;
            end
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_outst    <= '0;
            r_discard  <= '0;
        end else begin
            r_outst <= w_outst_next;
            if (bus.redirect_valid) begin
                r_fetch_pc <= bus.redirect_pc;
                r_rsp_pc   <= bus.redirect_pc;
                // Every request still in flight after this edge is stale; older
                // pending discards are already part of that outstanding count.
                r_discard  <= w_outst_next;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                if (w_rsp) begin
                    if (r_discard != '0) r_discard <= r_discard - OW'(1);
                    else                 r_rsp_pc  <= r_rsp_pc + ADDR_W'(1);
                end
            end
        end
    end

    inst_fetch_unit_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_keep),
        .din   ({r_rsp_pc, bus.imem_rsp_data}),
        .pop   (w_pop),
        .flush (bus.redirect_valid),
        .dout  (w_fifo_rd),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign bus.imem_req_valid        = w_issue;
    assign bus.imem_req_addr         = r_fetch_pc;
    assign bus.inst_valid            = ~w_fifo_empty;
    assign {bus.inst_pc, bus.inst_data} = w_fifo_rd;
    assign bus.halted                = (r_state == S_HALT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_outst <= OW'(MAX_OUTST));
            assert (!(w_rsp && (r_outst == '0)));
            assert (!(w_rsp && w_fifo_full));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_fetch_unit
// Brief  : Scoreboard bench with an in-order variable-latency memory model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_inst_fetch_unit;
    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 32;
    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 4;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    inst_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [31:0] addr; bit stale; int due; } mem_req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    mem_req_t    mem_q [$];
    exp_t        sb_q  [$];
    logic [31:0] acc_log [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 1;
    int last_due = 0;
    int n_acc = 0;
    int n_pop = 0;

    logic        t_rst, t_ready, t_inst_ready, t_redirect, t_halt;
    logic [31:0] t_redirect_pc, exp_addr, first_pc;
    bit          got_first, prev_redirect;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic check_value(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, then account for the handshakes of the coming posedge.
    task automatic cycle();
        bit       rsp_now;
        mem_req_t m;
        exp_t     e;
        int       due;
        @(negedge clk);
        rst                = t_rst;
        bus.imem_req_ready = t_ready;
        bus.inst_ready     = t_inst_ready;
        bus.redirect_valid = t_redirect;
        bus.redirect_pc    = t_redirect_pc;
        bus.halt_req       = t_halt;
        rsp_now = !t_rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        bus.imem_rsp_valid = rsp_now;
        bus.imem_rsp_data  = rsp_now ? mem_data(mem_q[0].addr) : 32'h0;
        #1;
        if (t_rst) begin
            mem_q.delete();
            sb_q.delete();
            acc_log.delete();
            exp_addr      = RESET_PC;
            last_due      = 0;
            got_first     = 0;
            prev_redirect = 0;
        end else begin
            if (bus.halted)    check_value("halted_with_outstanding", mem_q.size(), 0);
            if (t_redirect)    check_value("req_valid_in_redirect", bus.imem_req_valid, 0);
            if (prev_redirect) check_value("inst_valid_after_redirect", bus.inst_valid, 0);
            if (bus.inst_valid && t_inst_ready) begin
                n_pop++;
                if (!got_first) begin
                    got_first = 1;
                    first_pc  = bus.inst_pc;
                end
                check_value("sb_nonempty_on_pop", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_value("inst_pc", bus.inst_pc, e.pc);
                    check_value("inst_data", bus.inst_data, e.data);
                end
            end
            if (t_redirect) begin
                foreach (mem_q[i]) mem_q[i].stale = 1;
                sb_q.delete();
                acc_log.delete();
                exp_addr  = t_redirect_pc;
                got_first = 0;
            end
            if (rsp_now) begin
                m = mem_q.pop_front();
                if (!m.stale) begin
                    e.pc   = m.addr;
                    e.data = mem_data(m.addr);
                    sb_q.push_back(e);
                end
            end
            if (bus.imem_req_valid && t_ready) begin
                check_value("req_addr", bus.imem_req_addr, exp_addr);
                acc_log.push_back(bus.imem_req_addr);
                n_acc++;
                due      = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = due;
                m.addr   = bus.imem_req_addr;
                m.stale  = 0;
                m.due    = due;
                mem_q.push_back(m);
                exp_addr = exp_addr + 32'd1;
            end
            prev_redirect = t_redirect;
        end
        cyc++;
    endtask

    task automatic do_reset();
        t_rst = 1; t_ready = 0; t_inst_ready = 0; t_redirect = 0; t_halt = 0;
        cycle();
        check_value("rst_req_valid_gated", bus.imem_req_valid, 0);
        cycle();
        check_value("rst_req_valid", bus.imem_req_valid, 0);
        check_value("rst_inst_valid", bus.inst_valid, 0);
        check_value("rst_halted", bus.halted, 0);
        t_rst = 0;
    endtask

    task automatic drain();
        t_ready = 0; t_inst_ready = 1; t_redirect = 0;
        for (int i = 0; i < 60 && (mem_q.size() > 0 || sb_q.size() > 0); i++) cycle();
        check_value("drain_sb_empty", sb_q.size(), 0);
        cycle();
        check_value("drain_inst_valid", bus.inst_valid, 0);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        t_redirect = 1; t_redirect_pc = pc;
        cycle();
        t_redirect = 0;
    endtask

    initial begin
        int  a0;
        bit  hit;
        rst = 1'b1;
        bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
        bus.inst_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = '0; bus.halt_req = 0;
        t_redirect_pc = '0; exp_addr = RESET_PC; first_pc = '0;
        got_first = 0; prev_redirect = 0;

        // 1: sequential streaming at one instruction per cycle
        do_reset();
        lat = 1; t_ready = 1; t_inst_ready = 1;
        cycle();
        check_value("first_req_valid", bus.imem_req_valid, 1);
        check_value("first_req_addr", bus.imem_req_addr, RESET_PC);
        repeat (5) cycle();
        a0 = n_pop;
        repeat (20) cycle();
        check_value("steady_throughput", n_pop - a0, 20);
        drain();

        // 2: decode stalled, credits stop issue at DEPTH
        do_reset();
        t_ready = 1; t_inst_ready = 0;
        a0 = n_acc;
        repeat (20) cycle();
        check_value("stall_req_count", n_acc - a0, DEPTH);
        check_value("stall_req_valid", bus.imem_req_valid, 0);
        check_value("stall_inst_valid", bus.inst_valid, 1);
        check_value("stall_head_pc", bus.inst_pc, 0);
        check_value("stall_sb_depth", sb_q.size(), DEPTH);
        drain();

        // 3: redirect with three requests in flight
        lat = 8; t_inst_ready = 1;
        redirect_to(32'h5);
        t_ready = 1;
        a0 = n_acc;
        for (int i = 0; i < 10 && n_acc < a0 + 3; i++) cycle();
        t_ready = 0;
        check_value("pre_redirect_outst", mem_q.size(), 3);
        redirect_to(32'h40);
        t_ready = 1;
        for (int i = 0; i < 60 && !got_first; i++) cycle();
        check_value("redir_got_inst", got_first, 1);
        check_value("redir_first_pc", first_pc, 32'h40);
        check_value("redir_first_req", acc_log[0], 32'h40);
        drain();

        // 4: redirect coinciding with a response, then a second redirect
        lat = 2; t_ready = 1; t_inst_ready = 1;
        repeat (6) cycle();
        for (int i = 0; i < 10 && !(mem_q.size() > 0 && mem_q[0].due <= cyc); i++) cycle();
        hit = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        check_value("rsp_with_redirect", hit, 1);
        redirect_to(32'h200);
        redirect_to(32'h300);
        for (int i = 0; i < 40 && !got_first; i++) cycle();
        check_value("b2b_first_pc", first_pc, 32'h300);
        drain();

        // 5: halt with two outstanding, then resume
        lat = 4; t_inst_ready = 1;
        redirect_to(32'h100);
        t_ready = 1;
        a0 = n_acc;
        for (int i = 0; i < 10 && n_acc < a0 + 2; i++) cycle();
        check_value("halt_pre_outst", mem_q.size(), 2);
        t_halt = 1;
        a0 = n_acc;
        for (int i = 0; i < 20 && !bus.halted; i++) cycle();
        check_value("halt_reached", bus.halted, 1);
        repeat (3) cycle();
        check_value("halt_no_req", n_acc - a0, 0);
        t_halt = 0;
        for (int i = 0; i < 10 && n_acc == a0; i++) cycle();
        check_value("resume_addr", acc_log[2], 32'h102);
        drain();

        // 6: PC wrap and reset mid-burst
        lat = 3; t_inst_ready = 1;
        redirect_to(32'hFFFF_FFFE);
        t_ready = 1;
        repeat (5) cycle();
        check_value("wrap_last", acc_log[1], 32'hFFFF_FFFF);
        check_value("wrap_zero", acc_log[2], 32'h0);
        do_reset();
        t_ready = 1; t_inst_ready = 1;
        cycle();
        check_value("post_rst_req_valid", bus.imem_req_valid, 1);
        check_value("post_rst_req_addr", bus.imem_req_addr, RESET_PC);
        repeat (10) cycle();
        check_value("post_rst_first_pc", first_pc, RESET_PC);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
